// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter sequencer for the CPU fetch stage. Each cycle it picks one
// operation by fixed priority (stall > ret > call > jump > branch > increment)
// and updates the PC. Calls and returns go through an internal hardware
// return-address stack. All PC arithmetic is modulo 2^ADDR_WIDTH.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   stall     in   hold PC and stack this cycle
//   jump      in   load PC from target
//   branch    in   add sign-extended offset to PC
//   call      in   push addr+1, then load PC from target
//   ret       in   pop the return stack into PC
//   target    in   absolute destination for jump/call
//   offset    in   two's-complement branch displacement
//   clr_err   in   clear the sticky error flags
//   addr      out  current PC, registered
//   depth     out  number of valid return-stack entries
//   overflow  out  sticky: a call was made with the stack full
//   underflow out  sticky: a ret was made with the stack empty
module pc_sequencer #(
    parameter int ADDR_WIDTH   = 8,
    parameter int OFFSET_WIDTH = 8,
    parameter int STACK_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   stall,
    input  logic                                   jump,
    input  logic                                   branch,
    input  logic                                   call,
    input  logic                                   ret,
    input  logic [ADDR_WIDTH-1:0]                  target,
    input  logic [OFFSET_WIDTH-1:0]                offset,
    input  logic                                   clr_err,
    output logic [ADDR_WIDTH-1:0]                  addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]       depth,
    output logic                                   overflow,
    output logic                                   underflow
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [1:0]            sync_q;
    logic                  run;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]         depth_q, depth_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
    logic                  push_en;
    logic [IW-1:0]         push_idx;
    logic [IW-1:0]         pop_idx;
    logic [DW-1:0]         depth_m1;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] offset_ext;
    logic                  stack_full;

    assign run        = sync_q[1];
    assign addr_inc   = addr_q + 1'b1;
    assign offset_ext = ADDR_WIDTH'($signed(offset));
    assign stack_full = (depth_q == DW'(STACK_DEPTH));
    assign depth_m1   = depth_q - 1'b1;
    assign pop_idx    = depth_m1[IW-1:0];
    assign push_idx   = depth_q[IW-1:0];

    // Release synchroniser: run rises two edges after rst_n deasserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    // Operation select. Only the highest-priority request acts; the rest are
    // dropped. Flags clear unless a new error sets them in the same cycle.
    always_comb begin
        addr_d  = addr_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (run) begin
            if (clr_err) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            if (stall) begin
                addr_d = addr_q;
            end else if (ret) begin
                if (depth_q != '0) begin
                    addr_d  = stack[pop_idx];
                    depth_d = depth_m1;
                end else begin
                    unf_d  = 1'b1;
                    addr_d = addr_inc;
                end
            end else if (call) begin
                if (!stack_full) begin
                    push_en = 1'b1;
                    depth_d = depth_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                addr_d = target;
            end else if (jump) begin
                addr_d = target;
            end else if (branch) begin
                addr_d = addr_q + offset_ext;
            end else begin
                addr_d = addr_inc;
            end
        end
    end

    // Architectural state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= RESET_ADDR;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage has no reset; entries above depth are never read.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack[push_idx] <= addr_inc;
        end
    end

    assign addr      = addr_q;
    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the CPU fetch stage. It replaces the fixed 8-bit free-running counter with a configurable-width PC. It supports stall, absolute jump, signed relative branch, and call/return through an internal hardware return-address stack. The instruction-memory address comes straight from a register, and the control inputs come from the decode stage.

## Interface

Parameters:
- ADDR_WIDTH, 8: PC and address width in bits (≥ 4).
- OFFSET_WIDTH, 8: width of the signed branch offset (≤ ADDR_WIDTH).
- STACK_DEPTH, 4: return-stack entries (≥ 1).
- RESET_ADDR, 0: PC value while in reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and stack this cycle.
- jump  in  1  load PC from target.
- branch  in  1  add sign-extended offset to PC.
- call  in  1  push addr+1, then load PC from target.
- ret  in  1  pop stack into PC.
- target  in  ADDR_WIDTH  absolute destination for jump/call.
- offset  in  OFFSET_WIDTH  two's-complement branch displacement.
- clr_err  in  1  clear the sticky error flags.
- addr  out  ADDR_WIDTH  current PC, registered.
- depth  out  clog2(STACK_DEPTH+1)  number of valid stack entries.
- overflow  out  1  sticky flag: a call was made with the stack full.
- underflow  out  1  sticky flag: a ret was made with the stack empty.

## Operation

- Reset (rst_n=0) acts immediately, without waiting for a clock edge, and sets:
  - addr=RESET_ADDR, depth=0, overflow=0, underflow=0;
  - both release-synchroniser stages to 0;
  - stack contents to don't-care.
- Release synchroniser: two flops, shifted in 1 on each rising edge while rst_n=1. The `run` signal is the second stage. When run=0, addr holds RESET_ADDR and all control inputs are ignored.
- When run=1, one operation is chosen per cycle by fixed priority: stall > ret > call > jump > branch > increment.
  - stall: addr, stack, and depth unchanged. Flags unchanged, but clr_err is still honoured.
  - ret, depth>0: addr ← stack[depth-1]; depth−1.
  - ret, depth=0: underflow←1; addr←addr+1 (treated as increment).
  - call, depth<STACK_DEPTH: stack[depth] ← addr+1; depth+1; addr←target.
  - call, depth=STACK_DEPTH: push discarded; overflow←1; addr←target (jump still taken); depth unchanged.
  - jump: addr←target.
  - branch: addr ← addr + sign_extend(offset).
  - none of the above: addr←addr+1.
- Arithmetic is modulo 2^ADDR_WIDTH: incrementing the maximum address wraps to 0, and branches wrap in both directions. Pushed return address addr+1 wraps the same way.
- Flags are sticky until clr_err=1 or reset. If clr_err and a new error happen in the same cycle, the flag ends 1 (set wins).
- Lower-priority requests asserted alongside a higher-priority one are dropped, not queued.

## Timing

- Release latency:
  - rst_n rises before edge E0.
  - Stage 1 captures 1 at E0; stage 2 (run) at E1.
  - First PC change is at E2, so addr=RESET_ADDR through E1 and is RESET_ADDR+1 after E2 (no control inputs).
- Control inputs are sampled at the rising edge; the effect is visible on addr one cycle later. No combinational path runs from inputs to outputs.
- Throughput is one operation per cycle. A ret may directly follow a call; it returns the value pushed in the previous cycle (no bypass needed, since the stack is written at the edge).
- If rst_n asserts mid-operation, state clears immediately and any pending operation is abandoned.
- depth and the flags update on the same edge as addr.

## Test plan

- **Reset/release:** ADDR_WIDTH=8, RESET_ADDR=0x10.
  - Assert rst_n=0 mid-cycle → addr=0x10 immediately.
  - Release before E0 → addr=0x10 after E0 and E1, 0x11 after E2, 0x12 after E3.
- **Wrap and branch:**
  - addr=0xFF, no control → next 0x00.
  - addr=0x05, branch with offset=0xFE (−2) → 0x03.
  - addr=0x02, offset=0xFC → 0xFE.
- **Call/return nesting:** STACK_DEPTH=4.
  - addr=0x20, call target=0x80 → addr=0x80, depth=1.
  - call target=0x90 → depth=2.
  - ret → addr=0x81, depth=1.
  - ret → addr=0x21, depth=0.
- **Overflow/underflow:**
  - 5 consecutive calls with depth=4 → fifth jumps to target, depth stays 4, overflow=1.
  - 4 rets drain the stack → 5th ret gives addr+1 and underflow=1.
  - clr_err → both flags 0.
- **Priority and stall:**
  - stall+jump+call together → addr unchanged, depth unchanged.
  - ret+call+jump with depth=1 → pops only.
  - jump+branch → addr=target.
